// File: rtl/run_seq_detector_pkg.sv
// Shared constants and helpers for the run-length sequence detector.
package run_seq_pkg;

    localparam int unsigned MAX_STAGES = 15;

    // Smallest width that can hold the values 0..stages.
    function automatic int unsigned st_width(input int unsigned stages);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < stages + 1) w++;
        return w;
    endfunction

    // Default pattern entry: (i+1) truncated to sym_w bits.
    function automatic logic [7:0] def_sym(input int unsigned i, input int unsigned sym_w);
        logic [7:0] v;
        v = 8'(i + 1);
        for (int unsigned b = 0; b < 8; b++) begin
            if (b >= sym_w) v[b] = 1'b0;
        end
        return v;
    endfunction

endpackage

// File: rtl/run_seq_detector_pat_regs.sv
// Pattern register file: STAGES entries of SYM_W bits, reset to the default pattern.
module run_seq_pat_regs
    import run_seq_pkg::*;
#(
    parameter int unsigned SYM_W  = 2,
    parameter int unsigned STAGES = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           load,
    input  logic [3:0]                     idx,
    input  logic [SYM_W-1:0]               sym,
    output logic [STAGES-1:0][SYM_W-1:0]   pat
);

    logic [STAGES-1:0][SYM_W-1:0] pat_q;
    logic [STAGES-1:0][SYM_W-1:0] pat_d;

    // Indices at or beyond STAGES match no entry, so such writes vanish.
    always_comb begin
        pat_d = pat_q;
        for (int unsigned i = 0; i < STAGES; i++) begin
            if (load && 32'(idx) == i) pat_d[i] = sym;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                pat_q[i] <= SYM_W'(def_sym(i, SYM_W));
            end
        end else begin
            pat_q <= pat_d;
        end
    end

    assign pat = pat_q;

endmodule

// File: rtl/run_seq_detector.sv
// Run-length sequence detector (P0+ P1+ ... Pn-1+) with loadable pattern.
// Define RUN_SEQ_DET_COUNTER_EN to build the saturating match counter.
module run_seq_detector
    import run_seq_pkg::*;
#(
    parameter int unsigned SYM_W  = 2,
    parameter int unsigned STAGES = 3,
    parameter int unsigned CNT_W  = 8,
    localparam int unsigned ST_W  = st_width(STAGES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [SYM_W-1:0] num,
    input  logic             pat_load,
    input  logic [3:0]       pat_idx,
    input  logic [SYM_W-1:0] pat_sym,
    output logic             ans,
    output logic             match_pulse,
    output logic [CNT_W-1:0] match_cnt,
    output logic [ST_W-1:0]  stage
);

    logic [STAGES-1:0][SYM_W-1:0] pat;
    logic [ST_W-1:0] stage_q, stage_d, stage_nxt;
    logic            match_pulse_q, match_pulse_d;
    logic            load_hit, adv, rep, enter;

    run_seq_pat_regs #(
        .SYM_W  (SYM_W),
        .STAGES (STAGES)
    ) u_pat (
        .clk   (clk),
        .reset (reset),
        .load  (pat_load),
        .idx   (pat_idx),
        .sym   (pat_sym),
        .pat   (pat)
    );

    assign load_hit = pat_load && (32'(pat_idx) < STAGES);

    // adv: num equals the entry the current stage waits for; rep: it equals the one just matched.
    always_comb begin
        adv = 1'b0;
        rep = 1'b0;
        for (int unsigned s = 0; s < STAGES; s++) begin
            if (32'(stage_q) == s && num == pat[s])     adv = 1'b1;
            if (32'(stage_q) == s + 1 && num == pat[s]) rep = 1'b1;
        end
        if (adv)                 stage_nxt = stage_q + 1'b1;
        else if (rep)            stage_nxt = stage_q;
        else if (num == pat[0])  stage_nxt = ST_W'(1);
        else                     stage_nxt = '0;
    end

    always_comb begin
        stage_d       = stage_q;
        match_pulse_d = 1'b0;
        enter         = 1'b0;
        if (pat_load) begin
            if (load_hit) stage_d = '0;
        end else if (in_valid) begin
            stage_d       = stage_nxt;
            enter         = (32'(stage_nxt) == STAGES) && (32'(stage_q) != STAGES);
            match_pulse_d = enter;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q       <= '0;
            match_pulse_q <= 1'b0;
        end else begin
            stage_q       <= stage_d;
            match_pulse_q <= match_pulse_d;
        end
    end

`ifdef RUN_SEQ_DET_COUNTER_EN
    logic [CNT_W-1:0] match_cnt_q, match_cnt_d;

    always_comb begin
        match_cnt_d = match_cnt_q;
        if (enter && match_cnt_q != '1) match_cnt_d = match_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) match_cnt_q <= '0;
        else       match_cnt_q <= match_cnt_d;
    end

    assign match_cnt = match_cnt_q;
`else
    assign match_cnt = '0;
`endif

    assign stage       = stage_q;
    assign ans         = (32'(stage_q) == STAGES);
    assign match_pulse = match_pulse_q;

endmodule
